// File: rtl/javk_bus_pkg.sv
// Shared types and constants for the JAVK external bus controller.
package javk_bus_pkg;

    // Bus sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Width of the wait-state counter (0..15 extra DATA cycles).
    localparam int WAIT_W = 4;

    // Requester indices into the request/grant vectors.
    localparam logic R0 = 1'b0;
    localparam logic R1 = 1'b1;

    // Address of byte 'idx' of a transfer; wraps at 16 bits.
    function automatic logic [15:0] byte_addr(input logic [15:0] base, input logic [1:0] idx);
        return base + {14'd0, idx};
    endfunction

endpackage

// File: rtl/javk_rr_arb.sv
// Two-way arbiter: round-robin or fixed priority (r0 first), with a
// last-grant register that advances only when a grant is taken.
module javk_rr_arb
    import javk_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    // Grant selection: on contention pick the requester not served last,
    // unless fixed priority is selected.
    always_comb begin
        gnt = 2'b00;
        if (FIXED_PRIO != 0) begin
            if (req[R0]) begin
                gnt[R0] = 1'b1;
            end else if (req[R1]) begin
                gnt[R1] = 1'b1;
            end
        end else if (req[R0] && req[R1]) begin
            if (last_q == R1) begin
                gnt[R0] = 1'b1;
            end else begin
                gnt[R1] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

    // Next last-grant value: remember the winner when the grant is taken.
    always_comb begin
        last_d = last_q;
        if (upd && gnt[R0]) begin
            last_d = R0;
        end else if (upd && gnt[R1]) begin
            last_d = R1;
        end
    end

    // Last-grant register; resets to r1 so r0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= R1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/javk_bus_ctrl.sv
// External memory bus controller: arbitrates r0/r1 and sequences each
// transfer into byte cycles (ADDR, DATA with wait states), little-endian.
// Requesters hold req until a one-cycle ack; operands are latched at grant.
module javk_bus_ctrl
    import javk_bus_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int FIXED_PRIO  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic        r0_wide,
    input  logic [15:0] r0_addr,
    input  logic [15:0] r0_wdata,
    output logic        r0_ack,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic        r1_wide,
    input  logic [15:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r1_ack,
    output logic [15:0] rdata,
    output logic [15:0] addrbus,
    output logic        rw,
    output logic [7:0]  dataout,
    output logic        bus_oe,
    input  logic [7:0]  datain
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                wide_q, wide_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [1:0]          byte_q, byte_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          ack_q, ack_d;
    logic [15:0]         rdata_q, rdata_d;
    logic [15:0]         addrbus_q, addrbus_d;
    logic                rw_q, rw_d;
    logic [7:0]          dataout_q, dataout_d;
    logic                bus_oe_q, bus_oe_d;

    logic [1:0]          req_vec;
    logic [1:0]          arb_gnt;
    logic                arb_upd;
    logic                win_we;
    logic                win_wide;
    logic [15:0]         win_addr;
    logic [15:0]         win_wdata;

    assign req_vec = {r1_req, r0_req};
    assign arb_upd = (state_q == ST_IDLE) && (req_vec != 2'b00);

    javk_rr_arb #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_vec),
        .upd (arb_upd),
        .gnt (arb_gnt)
    );

    // Operand mux for the arbitration winner.
    always_comb begin
        if (arb_gnt[R1]) begin
            win_we    = r1_we;
            win_wide  = r1_wide;
            win_addr  = r1_addr;
            win_wdata = r1_wdata;
        end else begin
            win_we    = r0_we;
            win_wide  = r0_wide;
            win_addr  = r0_addr;
            win_wdata = r0_wdata;
        end
    end

    // Next-state and registered bus outputs; outputs are computed for the
    // state being entered so they are glitch-free flops at the pins.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        wide_d    = wide_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        byte_d    = byte_q;
        wait_d    = wait_q;
        gnt_d     = gnt_q;
        ack_d     = 2'b00;
        rdata_d   = rdata_q;
        addrbus_d = addrbus_q;
        rw_d      = rw_q;
        dataout_d = dataout_q;
        bus_oe_d  = bus_oe_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vec != 2'b00) begin
                    we_d      = win_we;
                    wide_d    = win_wide;
                    addr_d    = win_addr;
                    wdata_d   = win_wdata;
                    gnt_d     = arb_gnt;
                    byte_d    = 2'd0;
                    addrbus_d = byte_addr(win_addr, 2'd0);
                    rw_d      = win_we;
                    dataout_d = win_wdata[7:0];
                    bus_oe_d  = 1'b0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Turnaround cycle done; drive the bus only for writes.
                wait_d   = WAIT_INIT;
                bus_oe_d = we_q;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    // Last DATA cycle: the only point where datain is sampled.
                    if (!we_q) begin
                        if (byte_q == 2'd0) begin
                            rdata_d = {(wide_q ? rdata_q[15:8] : 8'h00), datain};
                        end else begin
                            rdata_d = {datain, rdata_q[7:0]};
                        end
                    end
                    bus_oe_d = 1'b0;
                    if (wide_q && (byte_q == 2'd0)) begin
                        byte_d    = 2'd1;
                        addrbus_d = byte_addr(addr_q, 2'd1);
                        dataout_d = wdata_q[15:8];
                        state_d   = ST_ADDR;
                    end else begin
                        ack_d   = gnt_q;
                        rw_d    = 1'b0;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            wide_q    <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            byte_q    <= 2'd0;
            wait_q    <= '0;
            gnt_q     <= 2'b00;
            ack_q     <= 2'b00;
            rdata_q   <= 16'h0000;
            addrbus_q <= 16'h0000;
            rw_q      <= 1'b0;
            dataout_q <= 8'h00;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            wide_q    <= wide_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            byte_q    <= byte_d;
            wait_q    <= wait_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            addrbus_q <= addrbus_d;
            rw_q      <= rw_d;
            dataout_q <= dataout_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    assign r0_ack  = ack_q[R0];
    assign r1_ack  = ack_q[R1];
    assign rdata   = rdata_q;
    assign addrbus = addrbus_q;
    assign rw      = rw_q;
    assign dataout = dataout_q;
    assign bus_oe  = bus_oe_q;

endmodule

// File: tb/tb_javk_bus_ctrl.sv
// Bench for javk_bus_ctrl: instance A (no wait states, round-robin) is
// checked through an ack/read scoreboard and a bus-write scoreboard;
// instance B (3 wait states, fixed priority) is checked directly.
module tb_javk_bus_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- instance A signals ----------------
    logic        a_r0_req, a_r0_we, a_r0_wide, a_r0_ack;
    logic        a_r1_req, a_r1_we, a_r1_wide, a_r1_ack;
    logic [15:0] a_r0_addr, a_r0_wdata, a_r1_addr, a_r1_wdata;
    logic [15:0] a_rdata, a_addrbus;
    logic        a_rw, a_bus_oe;
    logic [7:0]  a_dataout, a_datain;

    // ---------------- instance B signals ----------------
    logic        b_r0_req, b_r0_we, b_r0_wide, b_r0_ack;
    logic        b_r1_req, b_r1_we, b_r1_wide, b_r1_ack;
    logic [15:0] b_r0_addr, b_r0_wdata, b_r1_addr, b_r1_wdata;
    logic [15:0] b_rdata, b_addrbus;
    logic        b_rw, b_bus_oe;
    logic [7:0]  b_dataout, b_datain;

    // Read-only memory model behind instance A's bus.
    logic [7:0] rom [256];
    assign a_datain = rom[a_addrbus[7:0]];

    javk_bus_ctrl #(.WAIT_STATES(0), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst),
        .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_wide(a_r0_wide),
        .r0_addr(a_r0_addr), .r0_wdata(a_r0_wdata), .r0_ack(a_r0_ack),
        .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_wide(a_r1_wide),
        .r1_addr(a_r1_addr), .r1_wdata(a_r1_wdata), .r1_ack(a_r1_ack),
        .rdata(a_rdata), .addrbus(a_addrbus), .rw(a_rw),
        .dataout(a_dataout), .bus_oe(a_bus_oe), .datain(a_datain)
    );

    javk_bus_ctrl #(.WAIT_STATES(3), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_wide(b_r0_wide),
        .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata), .r0_ack(b_r0_ack),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_wide(b_r1_wide),
        .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata), .r1_ack(b_r1_ack),
        .rdata(b_rdata), .addrbus(b_addrbus), .rw(b_rw),
        .dataout(b_dataout), .bus_oe(b_bus_oe), .datain(b_datain)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // exp_q entry: [18]=is_read, [17:16]=expected ack one-hot, [15:0]=rdata
    localparam int W = 19;
    logic [W-1:0] exp_q[$];
    logic [23:0]  wr_q[$];   // {addr, byte} for each expected bus write

    always @(negedge clk) begin : sb_mon
        logic [W-1:0] e;
        logic [23:0]  w;
        if (!rst && (a_r0_ack || a_r1_ack)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ack", {30'd0, a_r1_ack, a_r0_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ack_id", {30'd0, a_r1_ack, a_r0_ack}, {30'd0, e[17:16]});
                if (e[18]) chk("sb_rdata", {16'd0, a_rdata}, {16'd0, e[15:0]});
            end
        end
        if (a_bus_oe) begin
            if (wr_q.size() == 0) begin
                chk("sb_unexpected_oe", {31'd0, a_bus_oe}, 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("sb_wr_addr", {16'd0, a_addrbus}, {16'd0, w[23:8]});
                chk("sb_wr_data", {24'd0, a_dataout}, {24'd0, w[7:0]});
                chk("sb_wr_rw", {31'd0, a_rw}, 32'd1);
            end
        end
    end

    // ---------------- driver tasks (instance A) ----------------
    task automatic push_exp(input logic id, input logic we, input logic wide,
                            input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0] a1;
        logic [15:0] d;
        logic [1:0]  oh;
        a1 = addr + 16'd1;
        oh = id ? 2'b10 : 2'b01;
        if (we) begin
            exp_q.push_back({1'b0, oh, 16'h0000});
            wr_q.push_back({addr, wdata[7:0]});
            if (wide) wr_q.push_back({a1, wdata[15:8]});
        end else begin
            d = wide ? {rom[a1[7:0]], rom[addr[7:0]]} : {8'h00, rom[addr[7:0]]};
            exp_q.push_back({1'b1, oh, d});
        end
    endtask

    task automatic drive_a(input logic id, input logic we, input logic wide,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (id) begin
            a_r1_we = we; a_r1_wide = wide; a_r1_addr = addr; a_r1_wdata = wdata; a_r1_req = 1'b1;
        end else begin
            a_r0_we = we; a_r0_wide = wide; a_r0_addr = addr; a_r0_wdata = wdata; a_r0_req = 1'b1;
        end
    endtask

    // Wait (bounded) for the requester's ack, then drop its req.
    task automatic wait_ack_a(input logic id, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = id ? a_r1_ack : a_r0_ack;
        end
        if (id) begin
            chk("ack_r1_seen", {31'd0, got}, 32'd1);
            a_r1_req = 1'b0;
        end else begin
            chk("ack_r0_seen", {31'd0, got}, 32'd1);
            a_r0_req = 1'b0;
        end
    endtask

    task automatic xfer_a(input logic id, input logic we, input logic wide,
                          input logic [15:0] addr, input logic [15:0] wdata, output int n);
        @(negedge clk);
        push_exp(id, we, wide, addr, wdata);
        drive_a(id, we, wide, addr, wdata);
        wait_ack_a(id, n);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        int  cnt;
        int  c0;
        int  c1;
        bit  got;
        logic rid, rwe, rwide;
        logic [15:0] raddr, rwd;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 11);
        rom[8'h34] = 8'hA5;
        rom[8'hFF] = 8'h11;
        rom[8'h00] = 8'h22;

        rst = 1'b1;
        a_r0_req = 0; a_r0_we = 0; a_r0_wide = 0; a_r0_addr = 0; a_r0_wdata = 0;
        a_r1_req = 0; a_r1_we = 0; a_r1_wide = 0; a_r1_addr = 0; a_r1_wdata = 0;
        b_r0_req = 0; b_r0_we = 0; b_r0_wide = 0; b_r0_addr = 0; b_r0_wdata = 0;
        b_r1_req = 0; b_r1_we = 0; b_r1_wide = 0; b_r1_addr = 0; b_r1_wdata = 0;
        b_datain = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_addrbus", {16'd0, a_addrbus}, 32'd0);
        chk("rst_rw_oe", {30'd0, a_rw, a_bus_oe}, 32'd0);
        chk("rst_dataout", {24'd0, a_dataout}, 32'd0);
        chk("rst_rdata", {16'd0, a_rdata}, 32'd0);
        chk("rst_acks", {28'd0, a_r1_ack, a_r0_ack, b_r1_ack, b_r0_ack}, 32'd0);
        rst = 1'b0;

        // r0 8-bit read @0x1234 -> 0x00A5 at T+3
        @(negedge clk);
        push_exp(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
        drive_a(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("t1_addr", {16'd0, a_addrbus}, 32'h1234);
            chk("t1_rw_oe", {30'd0, a_rw, a_bus_oe}, 32'd0);
        end
        wait_ack_a(1'b0, n);
        chk("t1_lat", n, 32'd1);

        // r1 16-bit write @0x2000 of 0xBEEF
        @(negedge clk);
        push_exp(1'b1, 1'b1, 1'b1, 16'h2000, 16'hBEEF);
        drive_a(1'b1, 1'b1, 1'b1, 16'h2000, 16'hBEEF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_addr", {16'd0, a_addrbus}, (k > 2) ? 32'h2001 : 32'h2000);
            chk("t2_dout", {24'd0, a_dataout}, (k > 2) ? 32'hBE : 32'hEF);
            chk("t2_oe", {31'd0, a_bus_oe}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        wait_ack_a(1'b1, n);
        chk("t2_lat", n, 32'd1);

        // r0 16-bit read @0xFFFF: address wraps, rdata 0x2211
        @(negedge clk);
        push_exp(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        drive_a(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        repeat (3) @(negedge clk);
        chk("t3_wrap_addr", {16'd0, a_addrbus}, 32'h0000);
        wait_ack_a(1'b0, n);
        chk("t3_lat", n, 32'd2);

        // Reset during the DATA phase of an r1 write
        @(negedge clk);
        wr_q.push_back({16'h2000, 8'h57});
        drive_a(1'b1, 1'b1, 1'b1, 16'h2000, 16'h1357);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        a_r1_req = 1'b0;
        @(negedge clk);
        chk("rmid_oe_rw", {30'd0, a_bus_oe, a_rw}, 32'd0);
        chk("rmid_addr", {16'd0, a_addrbus}, 32'd0);
        chk("rmid_ack", {30'd0, a_r1_ack, a_r0_ack}, 32'd0);
        chk("rmid_rdata", {16'd0, a_rdata}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // Both request after reset: r0 must win first.
        push_exp(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000);
        push_exp(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        drive_a(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000);
        drive_a(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        wait_ack_a(1'b0, n);
        chk("rmid_r0_lat", n, 32'd3);
        wait_ack_a(1'b1, n);

        // Round-robin contention: continuous reads alternate r0,r1,r0,r1
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
            push_exp(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        end
        drive_a(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        drive_a(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 4; k++) begin
            @(negedge clk);
            if (a_r0_ack || a_r1_ack) cnt++;
        end
        a_r0_req = 1'b0;
        a_r1_req = 1'b0;
        chk("rr_ack_count", cnt, 32'd4);

        // Random transfers with latency checks
        for (int i = 0; i < 10; i++) begin
            rid   = 1'($urandom_range(0, 1));
            rwe   = 1'($urandom_range(0, 1));
            rwide = 1'($urandom_range(0, 1));
            raddr = 16'($urandom_range(0, 65535));
            rwd   = 16'($urandom_range(0, 65535));
            xfer_a(rid, rwe, rwide, raddr, rwd, n);
            chk("rand_lat", n, rwide ? 32'd5 : 32'd3);
        end

        // Instance B: 3 wait states, datain sampled only on the last DATA cycle
        @(negedge clk);
        b_r0_we = 1'b0; b_r0_wide = 1'b0; b_r0_addr = 16'h0055; b_r0_req = 1'b1;
        @(negedge clk);
        chk("w3_addr", {16'd0, b_addrbus}, 32'h0055);
        chk("w3_oe_addr", {31'd0, b_bus_oe}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            b_datain = 8'($urandom_range(0, 8'h3B));
            chk("w3_no_early_ack", {31'd0, b_r0_ack}, 32'd0);
            chk("w3_oe_data", {31'd0, b_bus_oe}, 32'd0);
        end
        @(negedge clk);
        b_datain = 8'h3C;
        chk("w3_no_ack_t5", {31'd0, b_r0_ack}, 32'd0);
        @(negedge clk);
        chk("w3_ack", {31'd0, b_r0_ack}, 32'd1);
        chk("w3_rdata", {16'd0, b_rdata}, 32'h003C);
        b_r0_req = 1'b0;

        // Instance B: fixed priority, r1 starves while r0 is held
        @(negedge clk);
        b_datain = 8'h77;
        b_r0_addr = 16'h0001; b_r0_req = 1'b1;
        b_r1_we = 1'b0; b_r1_wide = 1'b0; b_r1_addr = 16'h0002; b_r1_req = 1'b1;
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 60 && c0 < 3; k++) begin
            @(negedge clk);
            if (b_r0_ack) c0++;
            if (b_r1_ack) c1++;
        end
        b_r0_req = 1'b0;
        chk("fp_r0_acks", c0, 32'd3);
        chk("fp_r1_starved", c1, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = b_r1_ack;
        end
        chk("fp_r1_ack", {31'd0, got}, 32'd1);
        chk("fp_r1_rdata", {16'd0, b_rdata}, 32'h0077);
        b_r1_req = 1'b0;

        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size() + wr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/javk_bus_ctrl.md
Name: javk_bus_ctrl

Overview:
External memory bus controller and arbiter for the JAVK CPU. It shares the single 8-bit data / 16-bit address bus between two internal requesters: r0 (instruction fetch) and r1 (load/store). It sequences each transfer into byte cycles with a configurable number of wait states. 16-bit transfers are split into two little-endian byte cycles. It sits between the core units and the top-level tri-state databus driver, which drives databus with dataout while bus_oe is high.

Parameters:
WAIT_STATES, 0, extra DATA-phase cycles per byte cycle (legal range 0..15).
FIXED_PRIO, 0, 0 = round-robin between r0 and r1; 1 = r0 always wins contention.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  reset, synchronous and active-high.
r0_req / r1_req  input  1  transfer request; held high until ack.
r0_we / r1_we  input  1  1 = write, 0 = read.
r0_wide / r1_wide  input  1  1 = 16-bit transfer, 0 = 8-bit.
r0_addr / r1_addr  input  16  byte address.
r0_wdata / r1_wdata  input  16  write data; [7:0] only when wide=0.
r0_ack / r1_ack  output  1  one-cycle completion pulse.
rdata  output  16  read result, shared; valid in the ack cycle.
addrbus  output  16  external address.
rw  output  1  1 = write cycle (core drives the bus), 0 = read.
dataout  output  8  write byte to the external bus.
bus_oe  output  1  databus drive enable.
datain  input  8  byte sampled from the external bus.

Behaviour:
- Reset: a cycle with rst high forces the following on the next edge: state IDLE, addrbus=0, rw=0, dataout=0, bus_oe=0, r0_ack=r1_ack=0, rdata=0, last-grant pointer=r1 (so r0 wins the first contention).
- Reset mid-transfer: the transfer is abandoned, bus_oe drops on the next edge, and no ack is issued.
- States: IDLE, ADDR, DATA, ACK. A 2-bit byte index and a 4-bit wait counter are kept internally.
- IDLE: if any req is high, arbitrate. Latch we, wide, addr and wdata of the winner, then go to ADDR.
  - FIXED_PRIO=0: on contention, grant the requester not granted last.
  - FIXED_PRIO=1: r0 always wins.
- ADDR (1 cycle):
  - addrbus = base address for byte 0, base+1 for byte 1. The 16-bit add wraps, so 0xFFFF+1 = 0x0000.
  - rw = we, bus_oe = 0. This cycle is also the bus turnaround.
  - dataout = wdata[7:0] for byte 0, wdata[15:8] for byte 1.
  - Next state is DATA; the wait counter is loaded with WAIT_STATES.
- DATA (WAIT_STATES+1 cycles):
  - addrbus, rw and dataout are held; bus_oe = we.
  - Read: datain is sampled only on the last DATA cycle, into rdata[7:0] (byte 0) or rdata[15:8] (byte 1).
  - Exit: if wide and on byte 0, go to ADDR for byte 1. Otherwise go to ACK.
- ACK (1 cycle):
  - The granted requester's ack = 1; rdata is valid.
  - For an 8-bit read, rdata[15:8] = 0.
  - bus_oe = 0, rw = 0. Next state is always IDLE.
- Latency (request seen in IDLE at cycle T):
  - 8-bit: ack at T+2+WAIT_STATES+1.
  - 16-bit: ack at T+2·(WAIT_STATES+2)+1.
- Requester rule: req must be low in the cycle after ack unless a new transfer is wanted. If req is still high there, it is treated as a new request.
- Operand changes after grant are ignored, because operands were latched in IDLE.
- bus_oe is never high in the cycle before or after a read DATA phase. The ADDR and ACK cycles guarantee this.
- rdata holds its value until the next read sample or reset.

Decomposition:
- Package javk_bus_pkg holds:
  - the state encoding (IDLE/ADDR/DATA/ACK);
  - the wait counter width (4);
  - the requester index constants R0=0, R1=1.
- Sub-module javk_rr_arb: a 2-way arbiter with req[1:0], an update strobe, the FIXED_PRIO parameter, a one-hot grant output and a last-grant register.

Test Plan:
- r0 8-bit read @0x1234, datain=0xA5, W=0, req at T -> addrbus=0x1234 and rw=0 at T+1..T+2; bus_oe=0 throughout; r0_ack=1 and rdata=0x00A5 at T+3.
- r1 16-bit write @0x2000, wdata=0xBEEF, W=0 -> T+1/T+2: addr 0x2000, dataout 0xEF, bus_oe=1 only at T+2; T+3/T+4: addr 0x2001, dataout 0xBE, bus_oe=1 only at T+4; r1_ack at T+5.
- r0 16-bit read @0xFFFF, datain 0x11 then 0x22 -> second byte cycle has addrbus=0x0000; rdata=0x2211 at ack.
- Both requesting continuous 8-bit reads, FIXED_PRIO=0 -> grants alternate r0,r1,r0,r1. With FIXED_PRIO=1 -> r1 never acked while r0 is held high.
- WAIT_STATES=3, r0 8-bit read -> DATA spans T+2..T+5; datain is sampled only at T+5 (changing datain at T+2..T+4 has no effect); ack at T+6.
- rst pulsed during the DATA phase of an r1 write -> next cycle bus_oe=0, rw=0, addrbus=0, no r1_ack. A following r0 request completes normally with r0 winning.
